// File: rtl/hc_scan_mux.sv
// Display scanner ahead of an hc4511 decoder: double-buffered BCD digits, time-sliced
// one-hot digit enables with an anti-ghost guard, and optional leading-zero blanking.
module hc_scan_mux #(
   parameter int DIGITS    = 4,
   parameter int PRESCALE  = 1000,
   parameter int BLANK_CYC = 2,
   parameter int LZB       = 1
) (
   input  logic                CP,
   input  logic                MR,
   input  logic [4*DIGITS-1:0] Dn,
   input  logic                LD,
   output logic [3:0]          Qn,
   output logic                BL_N,
   output logic [DIGITS-1:0]   Dig,
   output logic                Frame
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] P_LAST  = PW'(PRESCALE - 1);
   localparam logic [PW-1:0] P_GUARD = PW'(BLANK_CYC);
   localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);

   logic [PW-1:0]       r_pcnt;
   logic [DW-1:0]       r_didx;
   logic [4*DIGITS-1:0] r_cap;
   logic [4*DIGITS-1:0] r_shadow;
   logic                r_pend;
   logic [3:0]          r_qn;
   logic                r_bl_n;
   logic [DIGITS-1:0]   r_dig;
   logic                r_frame;

   logic                w_tick;
   logic                w_boundary;
   logic [PW-1:0]       w_pcnt_next;
   logic [DW-1:0]       w_didx_next;
   logic [4*DIGITS-1:0] w_shadow_next;
   logic                w_pend_next;
   logic [DIGITS:0]     w_zero_above;
   logic [DIGITS-1:0]   w_onehot;
   logic [3:0]          w_qn_next;
   logic                w_bl_n_next;
   logic [DIGITS-1:0]   w_dig_next;

   assign w_tick        = (r_pcnt == P_LAST);
   assign w_boundary    = w_tick && (r_didx == D_LAST);
   assign w_pcnt_next   = w_tick ? '0 : r_pcnt + 1'b1;
   assign w_didx_next   = w_boundary ? '0 : (w_tick ? r_didx + 1'b1 : r_didx);
   // The shadow only swaps at the frame boundary, so a frame is never torn.
   assign w_shadow_next = (w_boundary && r_pend) ? r_cap : r_shadow;
   assign w_pend_next   = LD || (r_pend && !w_boundary);

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_onehot
         assign w_onehot[gi] = (w_didx_next == DW'(gi));
      end
   endgenerate

   // w_zero_above[k]: every shadow digit from k upward is zero
   always_comb begin
      w_zero_above[DIGITS] = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         w_zero_above[k] = (w_shadow_next[4*k +: 4] == 4'd0) && w_zero_above[k+1];
      end
   end

   // Outputs are computed from next-state values so all of them move on the didx edge.
   always_comb begin
      w_qn_next   = 4'd0;
      w_bl_n_next = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (w_didx_next == DW'(k)) begin
            w_qn_next = w_shadow_next[4*k +: 4];
            if ((LZB != 0) && (k != 0) && w_zero_above[k]) begin
               w_bl_n_next = 1'b0;
            end
         end
      end
      w_dig_next = (w_pcnt_next < P_GUARD) ? '0 : w_onehot;
   end

   always_ff @(posedge CP or posedge MR) begin
      if (MR) begin
         r_pcnt   <= '0;
         r_didx   <= '0;
         r_cap    <= '0;
         r_shadow <= '0;
         r_pend   <= 1'b0;
         r_qn     <= 4'd0;
         r_bl_n   <= 1'b0;
         r_dig    <= '0;
         r_frame  <= 1'b0;
      end else begin
         r_pcnt   <= w_pcnt_next;
         r_didx   <= w_didx_next;
         r_shadow <= w_shadow_next;
         r_pend   <= w_pend_next;
         if (LD) begin
            r_cap <= Dn;
         end
         r_qn     <= w_qn_next;
         r_bl_n   <= w_bl_n_next;
         r_dig    <= w_dig_next;
         r_frame  <= w_boundary;
      end
   end

   assign Qn    = r_qn;
   assign BL_N  = r_bl_n;
   assign Dig   = r_dig;
   assign Frame = r_frame;
endmodule

// File: tb/tb_hc_scan_mux.sv
// Bench for hc_scan_mux: random loads against a time-arithmetic display model,
// plus fixed scenario checks for scan order, double buffering, blanking and async reset.
module tb_hc_scan_mux;
   localparam int D   = 4;
   localparam int P   = 4;
   localparam int BLK = 1;
   localparam int FR  = D * P;

   logic          CP = 1'b0;
   logic          MR = 1'b1;
   logic [15:0]   Dn = '0;
   logic          LD = 1'b0;
   logic [3:0]    qn1, qn0;
   logic          bln1, bln0;
   logic [3:0]    dig1, dig0;
   logic          fr1, fr0;

   hc_scan_mux #(.DIGITS(D), .PRESCALE(P), .BLANK_CYC(BLK), .LZB(1)) u_dut (
      .CP(CP), .MR(MR), .Dn(Dn), .LD(LD),
      .Qn(qn1), .BL_N(bln1), .Dig(dig1), .Frame(fr1)
   );

   hc_scan_mux #(.DIGITS(D), .PRESCALE(P), .BLANK_CYC(BLK), .LZB(0)) u_dut_nolzb (
      .CP(CP), .MR(MR), .Dn(Dn), .LD(LD),
      .Qn(qn0), .BL_N(bln0), .Dig(dig0), .Frame(fr0)
   );

   initial forever #5 CP = ~CP;

   int n_err = 0;
   int n_chk = 0;
   bit cmp_en = 1'b0;
   int cyc = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at time %0t", nm, act, exp, $time);
      end
   endtask

   // Model: time since reset release decides slot and phase; shadow/cap are plain arrays.
   int m_t = 0;
   bit m_pend = 1'b0;
   int m_cap [D];
   int m_shadow [D];

   initial begin
      for (int k = 0; k < D; k++) begin
         m_cap[k] = 0;
         m_shadow[k] = 0;
      end
      forever begin
         @(posedge CP or posedge MR);
         if (MR) begin
            m_t = 0;
            m_pend = 1'b0;
            for (int k = 0; k < D; k++) begin
               m_cap[k] = 0;
               m_shadow[k] = 0;
            end
         end else begin
            m_t++;
            if ((m_t % FR == 0) && m_pend) begin
               for (int k = 0; k < D; k++) m_shadow[k] = m_cap[k];
               m_pend = 1'b0;
            end
            if (LD) begin
               for (int k = 0; k < D; k++) m_cap[k] = int'(Dn[4*k +: 4]);
               m_pend = 1'b1;
            end
         end
      end
   end

   function automatic int exp_bln(input int lzb);
      int d;
      d = (m_t / P) % D;
      if (m_t == 0) return 0;
      if (lzb == 0 || d == 0) return 1;
      for (int j = d; j < D; j++) begin
         if (m_shadow[j] != 0) return 1;
      end
      return 0;
   endfunction

   initial begin
      int d, e_qn, e_dig, e_fr;
      wait (cmp_en);
      forever begin
         @(negedge CP);
         d     = (m_t / P) % D;
         e_qn  = (m_t == 0) ? 0 : m_shadow[d];
         e_dig = (m_t == 0 || (m_t % P) < BLK) ? 0 : (1 << d);
         e_fr  = (m_t != 0 && (m_t % FR) == 0) ? 1 : 0;
         chk("cyc_qn",       int'(qn1),  e_qn);
         chk("cyc_bl_n",     int'(bln1), exp_bln(1));
         chk("cyc_dig",      int'(dig1), e_dig);
         chk("cyc_frame",    int'(fr1),  e_fr);
         chk("cyc_qn_nolzb", int'(qn0),  e_qn);
         chk("cyc_bln_nolzb",int'(bln0), exp_bln(0));
         chk("cyc_dig_nolzb",int'(dig0), e_dig);
         chk("cyc_fr_nolzb", int'(fr0),  e_fr);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge CP);
      cyc += n;
   endtask

   task automatic goto_t(input int t);
      step(t - cyc);
   endtask

   task automatic load(input logic [15:0] v);
      LD = 1'b1;
      Dn = v;
      step(1);
      LD = 1'b0;
   endtask

   task automatic rst_pulse();
      LD = 1'b0;
      @(negedge CP);
      #2 MR = 1'b1;
      @(negedge CP);
      @(negedge CP);
      MR = 1'b0;
      cyc = 0;
   endtask

   function automatic logic [15:0] rand_dn();
      logic [15:0] v;
      v = '0;
      for (int k = 0; k < D; k++) begin
         v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      return v;
   endfunction

   int dig_log [2*FR+1];
   int fr_log  [2*FR+1];
   int t1_exp  [6] = '{0, 1, 1, 1, 0, 2};

   initial begin
      int fsum;
      repeat (3) @(negedge CP);
      chk("rst_qn",    int'(qn1),  0);
      chk("rst_bl_n",  int'(bln1), 0);
      chk("rst_dig",   int'(dig1), 0);
      chk("rst_frame", int'(fr1),  0);
      cmp_en = 1'b1;
      MR = 1'b0;
      cyc = 0;

      // scan order and frame pulse
      for (int c = 0; c <= 2*FR; c++) begin
         dig_log[c] = int'(dig1);
         fr_log[c]  = int'(fr1);
         if (c < 2*FR) step(1);
      end
      for (int c = 0; c < 6; c++) chk("t1_dig_seq", dig_log[c], t1_exp[c]);
      chk("t1_dig_slot2", dig_log[9], 4);
      chk("t1_dig_slot3", dig_log[13], 8);
      chk("t1_dig_wrap", dig_log[16], 0);
      fsum = 0;
      for (int c = 0; c < FR; c++) fsum += fr_log[c];
      chk("t1_no_frame_first", fsum, 0);
      chk("t1_frame16", fr_log[16], 1);
      chk("t1_frame17", fr_log[17], 0);
      chk("t1_frame32", fr_log[32], 1);

      // mid-frame load takes effect only after the boundary
      rst_pulse();
      goto_t(2);  chk("t2_d0_qn", int'(qn1), 0); chk("t2_d0_bln", int'(bln1), 1);
      goto_t(5);  load(16'h1234);
      goto_t(7);  chk("t2_d1_old_qn", int'(qn1), 0); chk("t2_d1_old_bln", int'(bln1), 0);
      goto_t(13); chk("t2_d3_old_bln", int'(bln1), 0);
      goto_t(17); chk("t2_d0_qn_new", int'(qn1), 4); chk("t2_d0_bln_new", int'(bln1), 1);
      goto_t(21); chk("t2_d1_qn_new", int'(qn1), 3);
      goto_t(25); chk("t2_d2_qn_new", int'(qn1), 2);
      goto_t(29); chk("t2_d3_qn_new", int'(qn1), 1); chk("t2_d3_bln_new", int'(bln1), 1);

      // leading-zero blanking
      goto_t(30); load(16'h0050);
      goto_t(34); chk("t3_d0_qn", int'(qn1), 0); chk("t3_d0_bln", int'(bln1), 1);
      goto_t(38); chk("t3_d1_qn", int'(qn1), 5); chk("t3_d1_bln", int'(bln1), 1);
      goto_t(42); chk("t3_d2_bln", int'(bln1), 0); chk("t3_d2_bln_nolzb", int'(bln0), 1);
      goto_t(46); chk("t3_d3_bln", int'(bln1), 0); chk("t3_d3_bln_nolzb", int'(bln0), 1);

      // non-BCD nibble passes through and counts as non-zero
      goto_t(50); load(16'h00A0);
      goto_t(66); chk("t5_d0_qn", int'(qn1), 0); chk("t5_d0_bln", int'(bln1), 1);
      goto_t(70); chk("t5_d1_qn", int'(qn1), 10); chk("t5_d1_bln", int'(bln1), 1);
      goto_t(74); chk("t5_d2_bln", int'(bln1), 0);
      goto_t(78); chk("t5_d3_bln", int'(bln1), 0);

      // load coincident with the frame boundary
      goto_t(100); load(16'h1111);
      goto_t(111); load(16'h2222);
      chk("t4_frame112", int'(fr1), 1);
      goto_t(113); chk("t4_f1_d0", int'(qn1), 1);
      goto_t(125); chk("t4_f1_d3", int'(qn1), 1);
      goto_t(129); chk("t4_f2_d0", int'(qn1), 2);
      goto_t(141); chk("t4_f2_d3", int'(qn1), 2);

      // random loads, checked by the model every cycle
      for (int i = 0; i < 640; i++) begin
         LD = ($urandom_range(0, 9) == 0);
         if (LD) Dn = rand_dn();
         step(1);
      end
      LD = 1'b0;

      // asynchronous reset mid slot 2
      load(16'h4321);
      step(FR);
      while (cyc % FR != 9) step(1);
      chk("t6_pre_dig", int'(dig1), 4);
      chk("t6_pre_qn", int'(qn1), 3);
      #2 MR = 1'b1;
      #1;
      chk("t6_async_qn",    int'(qn1),  0);
      chk("t6_async_bln",   int'(bln1), 0);
      chk("t6_async_dig",   int'(dig1), 0);
      chk("t6_async_frame", int'(fr1),  0);
      @(negedge CP);
      @(negedge CP);
      MR = 1'b0;
      cyc = 0;
      step(1);
      chk("t6_restart_dig", int'(dig1), 1);
      chk("t6_restart_qn", int'(qn1), 0);
      chk("t6_restart_bln", int'(bln1), 1);
      goto_t(5);
      chk("t6_shadow_clr_bln", int'(bln1), 0);

      step(4);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
